icache_2way: RTL
================

ICACHE_2WAY -- requirements
Module: icache_2way

Interface
REQ-001 Parameter SET_BITS, default 8, log2 of number of sets.
REQ-002 Parameter LINE_HW_BITS, default 4, log2 of 16-bit halfwords per line (default 32-byte line).
REQ-003 Parameter TAG_W, derived as 31-SET_BITS-LINE_HW_BITS (default 19); not overridable.
REQ-004 clk_i  in  1  single clock; all state changes on its rising edge.
REQ-005 rst_i  in  1  reset; synchronous, active-high.
REQ-006 adr_i  in  32  fetch address; bit 0 ignored.
REQ-007 stb_i  in  1  fetch request, qualified by adr_i.
REQ-008 hit_o  out  1  all 48 window bits valid for adr_i this cycle.
REQ-009 inst_o  out  16  halfword at adr_i.
REQ-010 data_o  out  32  {halfword adr_i+2, halfword adr_i+4}.
REQ-011 wb_adr_o  out  32  Wishbone master address, halfword aligned.
REQ-012 wb_dat_i  in  16  Wishbone read data.
REQ-013 wb_sel_o  out  2  constant 2'b11.
REQ-014 wb_cyc_o, wb_stb_o  out  1 each  equal; asserted for whole line fill.
REQ-015 wb_ack_i  in  1  one halfword accepted per cycle with ack high.
REQ-016 flush_i  in  1  invalidate-all request (present only under ICACHE_FLUSH_EN).
REQ-017 state_o  out  2  current FSM state (debug).

Function
REQ-018 Storage SHALL be 2 ways x 2^SET_BITS sets, each entry valid bit, TAG_W tag, 2^LINE_HW_BITS halfwords; one LRU bit per set.
REQ-019 Window halfwords h0,h1,h2 at adr_i, +2, +4 SHALL each map to set/offset independently; set increments with wrap when offset overflows line.
REQ-020 hit_o SHALL be combinational: !rst_i & state==IDLE & h0,h1,h2 each present in either way with matching tag.
REQ-021 inst_o/data_o SHALL be combinational, selected from hitting way per halfword; don't-care when hit_o=0.
REQ-022 FSM states IDLE(0), FILL(1), FLUSH(2).
REQ-023 IDLE: stb_i & !hit_o -> FILL, targeting lowest-address missing line (h0's line before h2's line); wb_adr_o <= line base; count <= 0.
REQ-024 Victim way: first invalid way (way0 preferred), else way not marked by LRU; latched at FILL entry.
REQ-025 FILL: each wb_ack_i writes wb_dat_i to victim[count], wb_adr_o += 2, count += 1; wb_stb_o held high.
REQ-026 On ack with count == 2^LINE_HW_BITS-1: write tag, set valid, set LRU to mark victim most-recent, deassert wb_stb_o same edge, -> IDLE.
REQ-027 Second missing line SHALL be filled by re-evaluation in IDLE; latency for two-line miss = two fills plus one IDLE cycle between.
REQ-028 stb_i deasserted or adr_i changed during FILL SHALL NOT abort the fill.
REQ-029 IDLE with stb_i & hit_o SHALL update LRU of h0's set to mark h0's hitting way most-recent.
REQ-030 wb_cyc_o/wb_stb_o SHALL be low in IDLE and FLUSH.

Reset
REQ-031 rst_i SHALL force state IDLE, count 0, wb_stb_o 0, wb_adr_o 0, all valid and LRU bits 0, hit_o 0, within one clock, including mid-FILL (partial line discarded, tag not written).
REQ-032 Line data and tag arrays SHALL NOT be reset.

Configuration
REQ-033 Macro ICACHE_FLUSH_EN defined: flush_i port exists; flush_i in IDLE -> FLUSH; FLUSH clears valid of one set (both ways) per cycle, set 0 upward, -> IDLE after set 2^SET_BITS-1; flush_i during FILL latched and honoured after fill completes; hit_o=0 in FLUSH; flush_i takes priority over a miss in IDLE.
REQ-034 Macro ICACHE_FLUSH_EN undefined: no flush_i port, no FLUSH state; only rst_i invalidates.

Verification
REQ-035 Reset, stb_i=1, adr_i=0x100 -> hit_o=0, one fill of 16 acks from 0x100..0x11E, then hit_o=1, inst_o=mem[0x100].
REQ-036 adr_i=0x11C cold -> fill 0x100 line, IDLE one cycle, fill 0x120 line; then hit_o=1, data_o={mem[0x11E],mem[0x120]}.
REQ-037 Fill 0x0000, 0x2000 (same set), access 0x0000, then 0x4000 -> 0x2000 way evicted; 0x0000 still hits.
REQ-038 rst_i asserted at ack 7 of fill -> wb_stb_o=0 next cycle, same address misses afterward.
REQ-039 ICACHE_FLUSH_EN: fill two lines, pulse flush_i -> 256 cycles FLUSH, then both addresses miss.
REQ-040 wb_ack_i held low 10 cycles mid-fill -> wb_adr_o and count stable, wb_stb_o stays high.

Source files
------------

// File: rtl/icache_2way.sv
// 2-way set-associative instruction cache: 48-bit fetch window (three halfwords), Wishbone line refill; ICACHE_FLUSH_EN adds flush_i.
// Hit is combinational in IDLE; a miss refills one line per fill (one halfword per ack) and stalls hit_o until the window is resident.
module icache_2way #(
    parameter int SET_BITS     = 8,
    parameter int LINE_HW_BITS = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] adr_i,
    input  logic        stb_i,
`ifdef ICACHE_FLUSH_EN
    input  logic        flush_i,
`endif
    output logic        hit_o,
    output logic [15:0] inst_o,
    output logic [31:0] data_o,
    output logic [31:0] wb_adr_o,
    input  logic [15:0] wb_dat_i,
    output logic [1:0]  wb_sel_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    input  logic        wb_ack_i,
    output logic [1:0]  state_o
);
    localparam int TAG_W   = 31 - SET_BITS - LINE_HW_BITS;
    localparam int SETS    = 1 << SET_BITS;
    localparam int LINE_HW = 1 << LINE_HW_BITS;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FILL  = 2'd1;
`ifdef ICACHE_FLUSH_EN
    localparam logic [1:0] ST_FLUSH = 2'd2;
`endif

    logic [15:0]             data_mem [2][SETS][LINE_HW];
    logic [TAG_W-1:0]        tag_mem  [2][SETS];
    logic [SETS-1:0]         valid    [2];
    logic [SETS-1:0]         lru;

    logic [1:0]              state;
    logic [LINE_HW_BITS-1:0] count;
    logic [SET_BITS-1:0]     fill_set;
    logic [TAG_W-1:0]        fill_tag;
    logic                    fill_way;
`ifdef ICACHE_FLUSH_EN
    logic [SET_BITS-1:0]     flush_set;
    logic                    flush_pend;
`endif

    logic [30:0]             hw      [3];
    logic [LINE_HW_BITS-1:0] hw_off  [3];
    logic [SET_BITS-1:0]     hw_set  [3];
    logic [TAG_W-1:0]        hw_tag  [3];
    logic [15:0]             hw_dat  [3];
    logic [2:0]              w0_hit;
    logic [2:0]              w1_hit;
    logic [2:0]              hw_hit;
    logic [2:0]              hw_way;
    logic                    all_hit;
    logic [30:0]             miss_hw;
    logic [SET_BITS-1:0]     miss_set;
    logic [TAG_W-1:0]        miss_tag;
    logic                    victim;
    logic                    unused_adr0;

    assign unused_adr0 = adr_i[0];

    // Each window halfword is looked up on its own, so a window may straddle two lines/sets.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            hw[i]     = adr_i[31:1] + 31'(i);
            hw_off[i] = hw[i][LINE_HW_BITS-1:0];
            hw_set[i] = hw[i][LINE_HW_BITS +: SET_BITS];
            hw_tag[i] = hw[i][30 -: TAG_W];
            w0_hit[i] = valid[0][hw_set[i]] && (tag_mem[0][hw_set[i]] == hw_tag[i]);
            w1_hit[i] = valid[1][hw_set[i]] && (tag_mem[1][hw_set[i]] == hw_tag[i]);
            hw_hit[i] = w0_hit[i] | w1_hit[i];
            hw_way[i] = ~w0_hit[i];
            hw_dat[i] = data_mem[hw_way[i]][hw_set[i]][hw_off[i]];
        end
    end

    assign all_hit = &hw_hit;
    assign hit_o   = !rst_i && (state == ST_IDLE) && all_hit;
    assign inst_o  = hw_dat[0];
    assign data_o  = {hw_dat[1], hw_dat[2]};

    // Lowest-address missing line first; the other one is picked up on re-evaluation in IDLE.
    assign miss_hw  = !hw_hit[0] ? hw[0] : (!hw_hit[1] ? hw[1] : hw[2]);
    assign miss_set = miss_hw[LINE_HW_BITS +: SET_BITS];
    assign miss_tag = miss_hw[30 -: TAG_W];
    assign victim   = !valid[0][miss_set] ? 1'b0 :
                      (!valid[1][miss_set] ? 1'b1 : ~lru[miss_set]);

    assign wb_stb_o = (state == ST_FILL);
    assign wb_cyc_o = wb_stb_o;
    assign wb_sel_o = 2'b11;
    assign state_o  = state;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= ST_IDLE;
            count    <= '0;
            wb_adr_o <= '0;
            valid[0] <= '0;
            valid[1] <= '0;
            lru      <= '0;
            fill_set <= '0;
            fill_tag <= '0;
            fill_way <= 1'b0;
`ifdef ICACHE_FLUSH_EN
            flush_set  <= '0;
            flush_pend <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (stb_i && all_hit)
                        lru[hw_set[0]] <= hw_way[0];
`ifdef ICACHE_FLUSH_EN
                    if (flush_i || flush_pend) begin
                        state      <= ST_FLUSH;
                        flush_set  <= '0;
                        flush_pend <= 1'b0;
                    end else
`endif
                    if (stb_i && !all_hit) begin
                        state    <= ST_FILL;
                        wb_adr_o <= {miss_hw & ~31'(LINE_HW - 1), 1'b0};
                        count    <= '0;
                        fill_set <= miss_set;
                        fill_tag <= miss_tag;
                        fill_way <= victim;
                    end
                end
                ST_FILL: begin
`ifdef ICACHE_FLUSH_EN
                    if (flush_i)
                        flush_pend <= 1'b1;
`endif
                    if (wb_ack_i) begin
                        wb_adr_o <= wb_adr_o + 32'd2;
                        count    <= count + 1'b1;
                        if (count == '1) begin
                            valid[fill_way][fill_set] <= 1'b1;
                            lru[fill_set]             <= fill_way;
                            state                     <= ST_IDLE;
                        end
                    end
                end
`ifdef ICACHE_FLUSH_EN
                ST_FLUSH: begin
                    valid[0][flush_set] <= 1'b0;
                    valid[1][flush_set] <= 1'b0;
                    flush_set           <= flush_set + 1'b1;
                    if (flush_set == '1)
                        state <= ST_IDLE;
                end
`endif
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Line data and tags carry no reset; the tag is only written on the final beat.
    always_ff @(posedge clk_i) begin
        if (!rst_i && (state == ST_FILL) && wb_ack_i) begin
            data_mem[fill_way][fill_set][count] <= wb_dat_i;
            if (count == '1)
                tag_mem[fill_way][fill_set] <= fill_tag;
        end
    end

endmodule
